// File: rtl/narrow_pkg.sv
// narrow_pkg: widths, saturation limits and buffered entry type for the 18-to-10 narrower
package narrow_pkg;
   localparam int IN_W  = 18;
   localparam int OUT_W = 10;
   localparam logic [OUT_W-1:0] SAT_POS = 10'h1FF;
   localparam logic [OUT_W-1:0] SAT_NEG = 10'h200;
   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             ovf;
   } entry_t;
endpackage

// File: rtl/narrow_if.sv
// narrow_if: valid/ready stream bundle for the narrower, input side plus output side
interface narrow_if
   import narrow_pkg::*;
   ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             sat_en;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;
   modport master (output in_valid, in_data, sat_en, out_ready,
                   input  in_ready, out_valid, out_data, out_ovf);
   modport slave  (input  in_valid, in_data, sat_en, out_ready,
                   output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/narrow_skid.sv
// narrow_skid: output register plus one-entry skid buffer; in_ready is registered (skid empty)
module narrow_skid #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         skid_v;
   logic [W-1:0] skid_d;
   logic         acc;
   logic         free;
   assign acc      = in_valid && !skid_v;
   assign free     = !out_valid || out_ready;
   assign in_ready = !skid_v;
   // refill the output register from the skid first, else from the input; park in skid when stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_v    <= 1'b0;
         skid_d    <= '0;
      end else if (free) begin
         out_valid <= skid_v || acc;
         if (skid_v) out_data <= skid_d;
         else if (acc) out_data <= in_data;
         skid_v <= 1'b0;
      end else if (acc) begin
         skid_v <= 1'b1;
         skid_d <= in_data;
      end
   end
endmodule

// File: rtl/narrower_18_to_10.sv
// narrower_18_to_10: range-check 18-bit signed values, saturate or wrap to 10 bits, buffer and count overflows
module narrower_18_to_10
   import narrow_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   narrow_if.slave          bus,
   input  logic             clr_status,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);
   logic [IN_W-OUT_W:0] hi;
   logic                fit;
   logic                acc_ovf;
   entry_t              ent;
   entry_t              q;
   assign hi      = bus.in_data[IN_W-1:OUT_W-1];
   assign fit     = (&hi) || !(|hi);
   assign acc_ovf = bus.in_valid && bus.in_ready && !fit;
   // fits or wrap mode keeps the low bits; saturate mode clamps by sign
   always_comb begin
      ent.ovf  = !fit;
      ent.data = (fit || !bus.sat_en) ? bus.in_data[OUT_W-1:0]
                                      : (bus.in_data[IN_W-1] ? SAT_NEG : SAT_POS);
   end
   narrow_skid #(.W($bits(entry_t))) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (ent),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (q)
   );
   assign bus.out_data = q.data;
   assign bus.out_ovf  = q.ovf;
   // overflow status; an accepted overflow beats a same-cycle clear and restarts the count at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (acc_ovf) begin
         ovf_sticky <= 1'b1;
         ovf_count  <= clr_status ? CNT_W'(1) : ((&ovf_count) ? ovf_count : ovf_count + 1'b1);
      end else if (clr_status) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end
   end
endmodule

// File: tb/tb_narrower_18_to_10.sv
// tb_narrower_18_to_10: directed checks of narrowing, buffering, status counters and async reset
module tb_narrower_18_to_10;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr_status;
   logic       ovf_sticky;
   logic [7:0] ovf_count;
   int         n_run  = 0;
   int         n_fail = 0;

   narrow_if bus ();

   narrower_18_to_10 #(.CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .clr_status (clr_status),
      .ovf_sticky (ovf_sticky),
      .ovf_count  (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      clr_status    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.sat_en    = 1'b1;
      bus.out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_out_ovf", 32'(bus.out_ovf), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_sticky", 32'(ovf_sticky), 0);
      chk("rst_count", 32'(ovf_count), 0);
      #9 rst_n = 1'b1;

      bus.in_valid = 1'b1;
      bus.in_data  = 18'h001FF;
      step();
      chk("fit_pos_valid", 32'(bus.out_valid), 1);
      chk("fit_pos_data", 32'(bus.out_data), 32'h1FF);
      chk("fit_pos_ovf", 32'(bus.out_ovf), 0);
      bus.in_data = 18'h3FE00;
      step();
      chk("fit_neg_data", 32'(bus.out_data), 32'h200);
      chk("fit_neg_ovf", 32'(bus.out_ovf), 0);
      bus.in_data = 18'h00000;
      step();
      chk("fit_zero_data", 32'(bus.out_data), 32'h000);
      chk("fit_zero_ovf", 32'(bus.out_ovf), 0);
      chk("fit_count", 32'(ovf_count), 0);

      bus.in_data = 18'h00200;
      step();
      chk("sat_pos_data", 32'(bus.out_data), 32'h1FF);
      chk("sat_pos_ovf", 32'(bus.out_ovf), 1);
      bus.sat_en = 1'b0;
      step();
      chk("wrap_data", 32'(bus.out_data), 32'h200);
      chk("wrap_ovf", 32'(bus.out_ovf), 1);
      chk("count_two", 32'(ovf_count), 2);
      chk("sticky_set", 32'(ovf_sticky), 1);
      bus.sat_en  = 1'b1;
      bus.in_data = 18'h20000;
      step();
      chk("sat_neg_data", 32'(bus.out_data), 32'h200);
      chk("sat_neg_ovf", 32'(bus.out_ovf), 1);
      bus.in_valid = 1'b0;
      step();
      chk("idle_valid", 32'(bus.out_valid), 0);
      chk("count_three", 32'(ovf_count), 3);

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 18'h00005;
      step();
      chk("bp_a_data", 32'(bus.out_data), 32'h005);
      chk("bp_a_ready", 32'(bus.in_ready), 1);
      bus.in_data = 18'h00006;
      step();
      chk("bp_skid_ready", 32'(bus.in_ready), 0);
      chk("bp_hold1_data", 32'(bus.out_data), 32'h005);
      bus.in_data = 18'h00007;
      step();
      chk("bp_hold2_data", 32'(bus.out_data), 32'h005);
      chk("bp_hold2_valid", 32'(bus.out_valid), 1);
      chk("bp_hold2_ready", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      step();
      chk("bp_b_data", 32'(bus.out_data), 32'h006);
      chk("bp_ready_back", 32'(bus.in_ready), 1);
      step();
      chk("bp_c_data", 32'(bus.out_data), 32'h007);
      bus.in_valid = 1'b0;
      step();
      chk("bp_empty", 32'(bus.out_valid), 0);

      bus.in_valid = 1'b1;
      bus.in_data  = 18'h10000;
      for (int i = 0; i < 300; i++) step();
      chk("count_sat", 32'(ovf_count), 32'hFF);
      chk("count_sat_sticky", 32'(ovf_sticky), 1);
      clr_status = 1'b1;
      step();
      chk("clr_vs_ovf_count", 32'(ovf_count), 1);
      chk("clr_vs_ovf_sticky", 32'(ovf_sticky), 1);
      bus.in_valid = 1'b0;
      step();
      chk("clr_count", 32'(ovf_count), 0);
      chk("clr_sticky", 32'(ovf_sticky), 0);
      clr_status = 1'b0;

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 18'h10000;
      step();
      bus.in_data = 18'h00012;
      step();
      chk("fill_ready", 32'(bus.in_ready), 0);
      chk("fill_count", 32'(ovf_count), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 0);
      chk("arst_ready", 32'(bus.in_ready), 1);
      chk("arst_count", 32'(ovf_count), 0);
      chk("arst_data", 32'(bus.out_data), 0);
      bus.in_data   = 18'h00033;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(bus.out_valid), 1);
      chk("post_rst_data", 32'(bus.out_data), 32'h033);
      bus.in_valid = 1'b0;
      step();
      chk("post_rst_drain", 32'(bus.out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
